// File: rtl/ctrl_seq.sv
// Multi-cycle FETCH/EXEC/MEM sequencer for the accumulator processor.
// Optional perf counters are built only when CTRL_PERF_CNT_EN is defined.
module ctrl_seq #(
  parameter int unsigned IW  = 9,
  parameter int unsigned OPW = 4,
  parameter int unsigned RAW = 4,
  parameter int unsigned CW  = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  input  logic [IW-1:0] Instruction,
  input  logic          instr_valid,
  input  logic          mem_ready,
  input  logic          br_cond,
  output logic          fetch_req,
  output logic          pc_en,
  output logic          jump_en,
  output logic          reg_exe,
  output logic          imm_exe,
  output logic          reg_to_acc,
  output logic          acc_to_reg,
  output logic          assign_val,
  output logic          sc_en,
  output logic          sc_clr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic          reg_wr_en,
  output logic [RAW-1:0] reg_wr_addr,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cyc_cnt,
  output logic [CW-1:0] ret_cnt
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StExec  = 3'd2;
  localparam logic [2:0] StMem   = 3'd3;
  localparam logic [2:0] StHalt  = 3'd4;

  localparam logic [OPW-1:0] OpLw     = OPW'(0);
  localparam logic [OPW-1:0] OpSw     = OPW'(1);
  localparam logic [OPW-1:0] OpAssign = OPW'(2);
  localparam logic [OPW-1:0] OpClrsc  = OPW'(3);
  localparam logic [OPW-1:0] OpMov    = OPW'(4);
  localparam logic [OPW-1:0] OpJmp    = OPW'(5);
  localparam logic [OPW-1:0] OpAdd    = OPW'(6);
  localparam logic [OPW-1:0] OpSub    = OPW'(7);
  localparam logic [OPW-1:0] OpAnd    = OPW'(8);
  localparam logic [OPW-1:0] OpOr     = OPW'(9);
  localparam logic [OPW-1:0] OpSl     = OPW'(10);
  localparam logic [OPW-1:0] OpSr     = OPW'(11);
  localparam logic [OPW-1:0] OpBeq    = OPW'(12);
  localparam logic [OPW-1:0] OpBne    = OPW'(13);
  localparam logic [OPW-1:0] OpBge    = OPW'(14);
  localparam logic [OPW-1:0] OpHalt   = OPW'(15);

  logic [2:0]     state_q, state_d;
  logic [IW-1:0]  ir_q, ir_d;
  logic [OPW-1:0] opcode;
  logic           mode;
  logic [RAW-1:0] rfield;
  logic           is_alu, is_br, is_shift_arith;

  assign opcode = ir_q[IW-1 -: OPW];
  assign mode   = ir_q[IW-OPW-1];
  assign rfield = ir_q[RAW-1:0];

  assign is_br  = (opcode == OpBeq) || (opcode == OpBne) || (opcode == OpBge);
  assign is_alu = is_br || (opcode == OpAdd) || (opcode == OpSub) ||
                  (opcode == OpAnd) || (opcode == OpOr);
  assign is_shift_arith = (opcode == OpAdd) || (opcode == OpSub) ||
                          (opcode == OpSl)  || (opcode == OpSr);

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    fetch_req   = 1'b0;
    pc_en       = 1'b0;
    jump_en     = 1'b0;
    reg_exe     = 1'b0;
    imm_exe     = 1'b0;
    reg_to_acc  = 1'b0;
    acc_to_reg  = 1'b0;
    assign_val  = 1'b0;
    sc_en       = 1'b0;
    sc_clr      = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    reg_wr_en   = 1'b0;
    reg_wr_addr = '1;
    busy        = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end

      StFetch: begin
        busy      = 1'b1;
        fetch_req = 1'b1;
        if (instr_valid) begin
          ir_d    = Instruction;
          state_d = StExec;
        end
      end

      StExec: begin
        busy       = 1'b1;
        reg_exe    = is_alu && !mode;
        imm_exe    = is_alu && mode;
        reg_to_acc = (opcode == OpMov) && !mode;
        acc_to_reg = (opcode == OpMov) && mode;
        assign_val = (opcode == OpAssign);
        sc_clr     = (opcode == OpClrsc);
        sc_en      = is_shift_arith;
        reg_wr_en  = !(is_br || (opcode == OpClrsc) || (opcode == OpSw) ||
                       (opcode == OpJmp) || (opcode == OpHalt) || (opcode == OpLw));
        if ((opcode == OpSl) || (opcode == OpSr) || (opcode == OpLw)) reg_wr_addr = rfield;

        if (opcode == OpJmp) begin
          jump_en = 1'b1;
        end else if (is_br) begin
          jump_en = br_cond;
          pc_en   = !br_cond;
        end else if ((opcode != OpLw) && (opcode != OpSw) && (opcode != OpHalt)) begin
          pc_en = 1'b1;
        end

        if ((opcode == OpLw) || (opcode == OpSw)) state_d = StMem;
        else if (opcode == OpHalt)                state_d = StHalt;
        else                                      state_d = StFetch;
      end

      StMem: begin
        busy = 1'b1;
        // Only LW/SW reach MEM, so anything other than LW is a store.
        if (opcode == OpLw) begin
          mem_rd      = 1'b1;
          reg_wr_addr = rfield;
        end else begin
          mem_wr = 1'b1;
        end
        if (mem_ready) begin
          pc_en     = 1'b1;
          reg_wr_en = (opcode == OpLw);
          state_d   = StFetch;
        end
      end

      StHalt: begin
        done = 1'b1;
        if (start) state_d = StFetch;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [CW-1:0] cyc_q, cyc_d;
  logic [CW-1:0] ret_q, ret_d;
  logic          halt_entry;

  assign halt_entry = (state_q == StExec) && (opcode == OpHalt);

  always_comb begin
    cyc_d = busy ? cyc_q + CW'(1) : cyc_q;
    ret_d = (pc_en || jump_en || halt_entry) ? ret_q + CW'(1) : ret_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;
`else
  assign cyc_cnt = '0;
  assign ret_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: per-cycle expected strobes are queued as stimulus is
// driven and compared at the following falling edge.
module tb_ctrl_seq;

  logic       Clk = 1'b0;
  logic       Reset, start, instr_valid, mem_ready, br_cond;
  logic [8:0] Instruction;
  logic       fetch_req, pc_en, jump_en, reg_exe, imm_exe, reg_to_acc, acc_to_reg;
  logic       assign_val, sc_en, sc_clr, mem_rd, mem_wr, reg_wr_en, busy, done;
  logic [3:0] reg_wr_addr;
  logic [15:0] cyc_cnt, ret_cnt;

  ctrl_seq #(.IW(9), .OPW(4), .RAW(4), .CW(16)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .Instruction(Instruction),
    .instr_valid(instr_valid), .mem_ready(mem_ready), .br_cond(br_cond),
    .fetch_req(fetch_req), .pc_en(pc_en), .jump_en(jump_en), .reg_exe(reg_exe),
    .imm_exe(imm_exe), .reg_to_acc(reg_to_acc), .acc_to_reg(acc_to_reg),
    .assign_val(assign_val), .sc_en(sc_en), .sc_clr(sc_clr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .busy(busy),
    .done(done), .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
  );

  always #5 Clk = ~Clk;

  localparam logic [14:0] FR  = 15'h4000, PC = 15'h2000, JE = 15'h1000, RE = 15'h0800;
  localparam logic [14:0] IE  = 15'h0400, RA = 15'h0200, AR = 15'h0100, AV = 15'h0080;
  localparam logic [14:0] SE  = 15'h0040, SCL = 15'h0020, MR = 15'h0010, MW = 15'h0008;
  localparam logic [14:0] WE  = 15'h0004, BZ = 15'h0002, DN = 15'h0001;
  localparam logic [3:0]  F   = 4'hF;

`ifdef CTRL_PERF_CNT_EN
  localparam logic [15:0] EXP_CYC = 16'd7;
  localparam logic [15:0] EXP_RET = 16'd3;
`else
  localparam logic [15:0] EXP_CYC = 16'd0;
  localparam logic [15:0] EXP_RET = 16'd0;
`endif

  typedef struct {
    logic [18:0] vec;
    bit          chk_cnt;
    logic [15:0] cyc;
    logic [15:0] ret;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [18:0] obs_vec;
  assign obs_vec = {fetch_req, pc_en, jump_en, reg_exe, imm_exe, reg_to_acc, acc_to_reg,
                    assign_val, sc_en, sc_clr, mem_rd, mem_wr, reg_wr_en, busy, done,
                    reg_wr_addr};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      check_eq(mon_e.tag, 32'(obs_vec), 32'(mon_e.vec));
      if (mon_e.chk_cnt) begin
        check_eq({mon_e.tag, "_cyc"}, 32'(cyc_cnt), 32'(mon_e.cyc));
        check_eq({mon_e.tag, "_ret"}, 32'(ret_cnt), 32'(mon_e.ret));
      end
    end
  end

  function automatic logic [8:0] ins(input logic [3:0] op, input logic m, input logic [3:0] r);
    return {op, m, r};
  endfunction

  task automatic push(input string tag, input logic [14:0] m, input logic [3:0] a);
    sb_q.push_back('{vec: {m, a}, chk_cnt: 1'b0, cyc: 16'd0, ret: 16'd0, tag: tag});
  endtask

  // One clock: queue expectation for the current cycle, then advance past the next edge.
  task automatic step(input string tag, input logic [14:0] m, input logic [3:0] a);
    push(tag, m, a);
    @(posedge Clk);
    #1;
  endtask

  task automatic step_cnt(input string tag, input logic [14:0] m, input logic [3:0] a,
                          input logic [15:0] c, input logic [15:0] r);
    sb_q.push_back('{vec: {m, a}, chk_cnt: 1'b1, cyc: c, ret: r, tag: tag});
    @(posedge Clk);
    #1;
  endtask

  logic [8:0]  t_ins [13];
  logic        t_bc  [13];
  logic [14:0] t_m   [13];
  logic [3:0]  t_a   [13];
  string       t_tag [13];

  initial begin
    t_ins = '{ins(4'd10, 1'b0, 4'd7), ins(4'd11, 1'b1, 4'd9), ins(4'd3, 1'b0, 4'd0),
              ins(4'd4, 1'b0, 4'd1),  ins(4'd4, 1'b1, 4'd1),  ins(4'd2, 1'b1, 4'd4),
              ins(4'd5, 1'b0, 4'd0),  ins(4'd7, 1'b0, 4'd2),  ins(4'd8, 1'b1, 4'd2),
              ins(4'd9, 1'b0, 4'd2),  ins(4'd12, 1'b0, 4'd0), ins(4'd14, 1'b1, 4'd0),
              ins(4'd6, 1'b0, 4'd1)};
    t_bc  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    t_m   = '{SE|PC|WE, SE|PC|WE, SCL|PC, RA|PC|WE, AR|PC|WE, AV|PC|WE, JE,
              RE|SE|PC|WE, IE|PC|WE, RE|PC|WE, RE|JE, IE|PC, RE|SE|PC|WE};
    t_a   = '{4'd7, 4'd9, F, F, F, F, F, F, F, F, F, F, F};
    t_tag = '{"exec_sl", "exec_sr", "exec_clrsc", "exec_mov0", "exec_mov1", "exec_assign",
              "exec_jmp", "exec_sub_reg", "exec_and_imm", "exec_or_reg", "exec_beq_taken",
              "exec_bge_fall", "exec_add_reg"};

    Reset = 1'b1; start = 1'b0; instr_valid = 1'b0; mem_ready = 1'b0; br_cond = 1'b0;
    Instruction = '0;
    @(posedge Clk);
    #1;
    step_cnt("reset", 15'h0, F, 16'd0, 16'd0);
    Reset = 1'b0;

    // ADD imm, LW (ready at once), HALT: counters checked once in HALT.
    start = 1'b1;
    step("idle_start", 15'h0, F);
    start = 1'b0; Instruction = ins(4'd6, 1'b1, 4'd3); instr_valid = 1'b1;
    step("fetch_add", FR|BZ, F);
    instr_valid = 1'b0;
    step("exec_add_imm", IE|SE|WE|PC|BZ, F);
    Instruction = ins(4'd0, 1'b0, 4'd5); instr_valid = 1'b1;
    step("fetch_lw1", FR|BZ, F);
    instr_valid = 1'b0;
    step("exec_lw1", BZ, 4'd5);
    mem_ready = 1'b1;
    step("mem_lw1", MR|PC|WE|BZ, 4'd5);
    mem_ready = 1'b0; Instruction = ins(4'd15, 1'b0, 4'd0); instr_valid = 1'b1;
    step("fetch_halt", FR|BZ, F);
    instr_valid = 1'b0;
    step("exec_halt", BZ, F);
    start = 1'b1;
    step_cnt("halt_done", DN, F, EXP_CYC, EXP_RET);

    // start while busy must not disturb FETCH/EXEC.
    step("fetch_wait_start", FR|BZ, F);
    start = 1'b0; Instruction = ins(4'd13, 1'b0, 4'd2); instr_valid = 1'b1;
    step("fetch_bne1", FR|BZ, F);
    instr_valid = 1'b0; br_cond = 1'b1; start = 1'b1;
    step("exec_bne_taken", RE|JE|BZ, F);
    start = 1'b0; br_cond = 1'b0; Instruction = ins(4'd13, 1'b1, 4'd2); instr_valid = 1'b1;
    step("fetch_bne2", FR|BZ, F);
    instr_valid = 1'b0;
    step("exec_bne_fall", IE|PC|BZ, F);

    for (int i = 0; i < 13; i++) begin
      Instruction = t_ins[i]; instr_valid = 1'b1; br_cond = t_bc[i];
      step("fetch_tbl", FR|BZ, F);
      instr_valid = 1'b0;
      step(t_tag[i], t_m[i]|BZ, t_a[i]);
    end
    br_cond = 1'b0;

    // LW r5 with three wait cycles; mem_ready during EXEC is ignored.
    Instruction = ins(4'd0, 1'b0, 4'd5); instr_valid = 1'b1;
    step("fetch_lw2", FR|BZ, F);
    instr_valid = 1'b0; mem_ready = 1'b1;
    step("exec_lw2", BZ, 4'd5);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("mem_lw2_wait", MR|BZ, 4'd5);
    mem_ready = 1'b1;
    step("mem_lw2_done", MR|PC|WE|BZ, 4'd5);
    mem_ready = 1'b0;

    // SW interrupted by reset in its second MEM cycle.
    Instruction = ins(4'd1, 1'b0, 4'd3); instr_valid = 1'b1;
    step("fetch_sw", FR|BZ, F);
    instr_valid = 1'b0;
    step("exec_sw", BZ, F);
    step("mem_sw_1", MW|BZ, F);
    push("mem_sw_2", MW|BZ, F);
    @(negedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    check_eq("reset_mid_mem", 32'(obs_vec), 32'({15'h0, F}));
    check_eq("reset_mid_mem_cyc", 32'(cyc_cnt), 32'd0);
    check_eq("reset_mid_mem_ret", 32'(ret_cnt), 32'd0);
    @(posedge Clk);
    #1;
    step("reset_hold", 15'h0, F);
    Reset = 1'b0;
    step("idle_after_reset", 15'h0, F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
